// File: rtl/uart_tx_framer_if.sv
// Byte handshake and shift-stage link for the UART TX framer.
// master drives the request and ser_data; slave is the framer.
interface uart_tx_framer_if #(
  parameter int Data_Wd = 8
);
  logic [Data_Wd-1:0] P_DATA;
  logic               Data_Valid;
  logic               PAR_EN;
  logic               PAR_TYP;
  logic               ser_data;
  logic               ser_en;
  logic               Busy;
  logic               TX_OUT;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data,
    input  ser_en, Busy, TX_OUT
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data,
    output ser_en, Busy, TX_OUT
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART TX frame controller: start, data, optional parity, stop.
// One CLK period is one bit time on TX_OUT.
module uart_tx_framer #(
  parameter int Data_Wd   = 8,
  parameter int Count_Wd  = 3,
  parameter int Stop_Bits = 1
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_framer_if.slave bus
);

  localparam int S_IDLE  = 0;
  localparam int S_START = 1;
  localparam int S_DATA  = 2;
  localparam int S_PAR   = 3;
  localparam int S_STOP  = 4;

  localparam logic [4:0] IDLE   = 5'b00001;
  localparam logic [4:0] START  = 5'b00010;
  localparam logic [4:0] DATA   = 5'b00100;
  localparam logic [4:0] PARITY = 5'b01000;
  localparam logic [4:0] STOP   = 5'b10000;

  localparam logic [Count_Wd-1:0] CNT_LAST =
    Count_Wd'(Data_Wd - 1);
  localparam logic STOP_LAST = 1'(Stop_Bits - 1);

  logic [4:0]          state;
  logic [Count_Wd-1:0] cnt;
  logic                par_bit;
  logic                par_en_q;
  logic                stop_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
      stop_cnt <= 1'b0;
    end else begin
      unique case (1'b1)
        state[S_IDLE]: begin
          if (bus.Data_Valid) begin
            state    <= START;
            par_bit  <= (^bus.P_DATA) ^ bus.PAR_TYP;
            par_en_q <= bus.PAR_EN;
          end
        end
        state[S_START]: begin
          state <= DATA;
          cnt   <= '0;
        end
        state[S_DATA]: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= par_en_q ? PARITY : STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        state[S_PAR]: state <= STOP;
        state[S_STOP]: begin
          // never straight to START: one IDLE cycle between frames
          if (stop_cnt == STOP_LAST) begin
            stop_cnt <= 1'b0;
            state    <= IDLE;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic tx;
  logic busy;
  logic en;

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    en   = 1'b0;
    unique case (1'b1)
      state[S_IDLE]:  busy = 1'b0;
      state[S_START]: tx   = 1'b0;
      state[S_DATA]: begin
        tx = bus.ser_data;
        en = 1'b1;
      end
      state[S_PAR]:   tx   = par_bit;
      state[S_STOP]:  tx   = 1'b1;
      default:        busy = 1'b0;
    endcase
  end

  assign bus.TX_OUT = tx;
  assign bus.Busy   = busy;
  assign bus.ser_en = en;

endmodule
